// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode/state types and opcode stepping helper for the calculator front end
package calc_pkg;

    localparam int OP_COUNT = 11;

    typedef enum logic [3:0] {
        OP_SUM        = 4'd0,
        OP_SUB        = 4'd1,
        OP_QUOT       = 4'd2,
        OP_MUL        = 4'd3,
        OP_REM        = 4'd4,
        OP_SQRT       = 4'd5,
        OP_CMP        = 4'd6,
        OP_DERIV_BASE = 4'd7,
        OP_DERIV_X    = 4'd8,
        OP_A_SQ       = 4'd9,
        OP_B_SQ       = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        SELECT   = 2'd2,
        WAIT_ACK = 2'd3
    } entry_state_e;

    // Step to the next opcode, wrapping from count-1 back to 0.
    function automatic logic [3:0] next_opcode(input logic [3:0] op, input int count);
        if (int'(op) >= count - 1) begin
            return 4'd0;
        end
        return op + 4'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button: 2-flop sync, debounce filter (OPERAND_ENTRY_DEBOUNCE_EN), rising-edge event
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_evt
);

    logic r_sync1;
    logic r_sync2;
    logic r_filt;
    logic r_filt_d;

    // A zero-length filter would never settle, so refuse it at elaboration.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 != r_filt) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end
`else
    // Bypass: filtered level simply follows the synchronized sample one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
        end else begin
            r_filt <= r_sync2;
        end
    end
`endif

    // Delayed filtered level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
        end
    end

    assign o_evt = r_filt & ~r_filt_d;

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - calculator input front end: button events to a registered A/B/opcode command (OPERAND_ENTRY_DEBOUNCE_EN selects debounce)
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OP_COUNT        = calc_pkg::OP_COUNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [3:0] btn,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] opcode,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] stage
);

    logic [7:0]               r_sw_s1;
    logic [7:0]               r_sw_s2;
    logic [3:0]               w_evt;
    logic                     w_unused_sw;
    logic                     w_enter;
    logic                     w_next;
    logic                     w_exec;
    logic                     w_clr;
    calc_pkg::entry_state_e   r_state;
    logic [3:0]               r_a;
    logic [3:0]               r_b;
    logic [3:0]               r_op;
    logic                     r_valid;

    // Switches only need synchronizing; the entry nibble is sampled on enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1 <= 8'd0;
            r_sw_s2 <= 8'd0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign w_unused_sw = ^r_sw_s2[7:4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .i_btn (btn[gi]),
            .o_evt (w_evt[gi])
        );
    end

    assign w_enter = w_evt[0];
    assign w_next  = w_evt[1];
    assign w_exec  = w_evt[2];
    assign w_clr   = w_evt[3];

    // Entry sequencer; the highest-priority event of a cycle is the only one considered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= calc_pkg::ENTER_A;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 4'd0;
            r_valid <= 1'b0;
        end else if (r_state == calc_pkg::WAIT_ACK) begin
            if (cmd_ready) begin
                r_valid <= 1'b0;
                r_state <= calc_pkg::SELECT;
            end
        end else if (w_clr) begin
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 4'd0;
            r_state <= calc_pkg::ENTER_A;
        end else if (w_exec) begin
            if (r_state == calc_pkg::SELECT) begin
                r_valid <= 1'b1;
                r_state <= calc_pkg::WAIT_ACK;
            end
        end else if (w_enter) begin
            case (r_state)
                calc_pkg::ENTER_A: begin
                    r_a     <= r_sw_s2[3:0];
                    r_state <= calc_pkg::ENTER_B;
                end
                calc_pkg::ENTER_B: begin
                    r_b     <= r_sw_s2[3:0];
                    r_state <= calc_pkg::SELECT;
                end
                default: begin
                end
            endcase
        end else if (w_next) begin
            if (r_state == calc_pkg::SELECT) begin
                r_op <= calc_pkg::next_opcode(r_op, OP_COUNT);
            end
        end
    end

    assign op_a      = r_a;
    assign op_b      = r_b;
    assign opcode    = r_op;
    assign cmd_valid = r_valid;
    assign stage     = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - randomized self-checking bench for operand_entry against a press-level model
module tb_operand_entry;

    localparam int DB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int L = DB + 2;
`else
    localparam int L = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [3:0] btn;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] opcode;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] stage;

    int total = 0;
    int bad   = 0;

    // Press-level model of the user-visible state
    logic [3:0] m_a;
    logic [3:0] m_b;
    int         m_op;
    logic [1:0] m_stage;
    logic       m_valid;

    operand_entry #(
        .DEBOUNCE_CYCLES(DB),
        .OP_COUNT(11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn       (btn),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [14:0] obs = {stage, cmd_valid, opcode, op_b, op_a};

    function automatic logic [14:0] exp_vec();
        logic [3:0] op4;
        op4 = m_op[3:0];
        return {m_stage, m_valid, op4, m_b, m_a};
    endfunction

    task automatic model_reset();
        m_a = 4'd0; m_b = 4'd0; m_op = 0; m_stage = 2'd0; m_valid = 1'b0;
    endtask

    // One user press (possibly several buttons at once) at the model level.
    task automatic model_press(input logic [3:0] mask);
        if (m_stage == 2'd3) return;
        if (mask[3]) begin
            m_a = 0; m_b = 0; m_op = 0; m_stage = 2'd0;
        end else if (mask[2]) begin
            if (m_stage == 2'd2) begin m_valid = 1'b1; m_stage = 2'd3; end
        end else if (mask[0]) begin
            if (m_stage == 2'd0) begin m_a = sw[3:0]; m_stage = 2'd1; end
            else if (m_stage == 2'd1) begin m_b = sw[3:0]; m_stage = 2'd2; end
        end else if (mask[1]) begin
            if (m_stage == 2'd2) m_op = (m_op + 1) % 11;
        end
    endtask

    task automatic model_ack();
        if (m_stage == 2'd3) begin m_valid = 1'b0; m_stage = 2'd2; end
    endtask

    task automatic press(input logic [3:0] mask);
        model_press(mask);
        @(negedge clk) btn = mask;
        repeat (L + 1) @(negedge clk);
        btn = 4'd0;
        repeat (L + 2) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk) cmd_ready = 1'b1;
        model_ack();
        @(negedge clk) cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 8'd0; btn = 4'd0; cmd_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("FAIL reset: got %h want %h", obs, 15'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        sw = 8'h05; press(4'b0001);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL basic_a: got %h want %h", obs, exp_vec()); end
        sw = 8'h03; press(4'b0001);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL basic_b: got %h want %h", obs, exp_vec()); end
        press(4'b0100);
        total++;
        if (obs !== {2'd3, 1'b1, 4'd0, 4'd3, 4'd5}) begin
            bad++; $display("FAIL basic_exec: got %h want %h", obs, {2'd3, 1'b1, 4'd0, 4'd3, 4'd5});
        end
        ack_pulse();
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL basic_ack: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_latency();
        press(4'b1000);
        sw = 8'($urandom_range(0, 255));
        @(negedge clk) btn = 4'b0001;
        repeat (L) @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL latency_early: got %h want %h", obs, exp_vec()); end
        model_press(4'b0001);
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL latency_edge: got %h want %h", obs, exp_vec()); end
        repeat (12) @(negedge clk);
        btn = 4'd0;
        repeat (L + 2) @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL latency_held: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_bounce();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
        logic [4:0] pat;
        pat = 5'b11011;
        sw = 8'($urandom_range(0, 255));
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk) btn[0] = pat[i];
        end
        @(negedge clk) btn = 4'd0;
        repeat (15) @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_glitch: got %h want %h", obs, exp_vec()); end
        @(negedge clk) btn = 4'b0001;
        repeat (L) @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_early: got %h want %h", obs, exp_vec()); end
        model_press(4'b0001);
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_edge: got %h want %h", obs, exp_vec()); end
        repeat (3) @(negedge clk);
        btn = 4'd0;
        repeat (L + 2) @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_single: got %h want %h", obs, exp_vec()); end
`endif
    endtask

    task automatic test_wrap();
        while (m_stage != 2'd2) press(4'b0001);
        for (int i = 0; i < 11; i++) press(4'b0010);
        total++;
        if (opcode !== 4'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL wrap_11: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 3; i++) press(4'b0010);
        total++;
        if (opcode !== 4'd3 || obs !== exp_vec()) begin
            bad++; $display("FAIL wrap_3: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_handshake();
        logic [14:0] held;
        press(4'b0100);
        held = exp_vec();
        total++;
        if (obs !== held) begin bad++; $display("FAIL hs_issue: got %h want %h", obs, held); end
        press(4'b1000);
        press(4'b0010);
        total++;
        if (obs !== held) begin bad++; $display("FAIL hs_frozen: got %h want %h", obs, held); end
        ack_pulse();
        total++;
        if (obs !== exp_vec() || cmd_valid !== 1'b0 || stage !== 2'd2) begin
            bad++; $display("FAIL hs_ack: got %h want %h", obs, exp_vec());
        end
        @(negedge clk) cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmd_ready = 1'b0;
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL hs_idle_ready: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_priority();
        press(4'b1100);
        total++;
        if (obs !== 15'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL priority: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int k;
        int d;
        for (int it = 0; it < 6; it++) begin
            press(4'b1000);
            sw = 8'($urandom_range(0, 255)); press(4'b0001);
            sw = 8'($urandom_range(0, 255)); press(4'b0001);
            k = $urandom_range(0, 14);
            for (int j = 0; j < k; j++) press(4'b0010);
            press(4'b0100);
            d = $urandom_range(0, 10);
            repeat (d) @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random_cmd it%0d: got %h want %h", it, obs, exp_vec()); end
            ack_pulse();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random_ack it%0d: got %h want %h", it, obs, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        press(4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 15'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL reset_mid: got %h want %h", obs, exp_vec());
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_bounce();
        test_wrap();
        test_handshake();
        test_priority();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end input block for the calculator: filters the four raw push-buttons and eight slide switches, steps the user through operand A, operand B and operation selection, and issues one registered command (A, B, opcode) to the arithmetic datapath over a valid/ready handshake. It is the input-side counterpart of the display path: where the display path turns results into scanned digits, this block turns raw human input into clean, single-cycle command events.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a filtered button changes state (≥1)
- OP_COUNT, 11, number of opcodes; opcode wraps from OP_COUNT-1 to 0

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw  in  8  raw slide switches; sw[3:0] is the entry nibble
- btn  in  4  raw buttons: [0] enter, [1] next-op, [2] execute, [3] clear
- op_a  out  4  captured operand A
- op_b  out  4  captured operand B
- opcode  out  4  selected operation (0 sum, 1 subtract, 2 quotient, 3 multiply, 4 remainder, 5 sqrt, 6 compare, 7 derivative base, 8 derivative X, 9 A², 10 B²)
- cmd_valid  out  1  command available
- cmd_ready  in  1  datapath accepts command
- stage  out  2  current state encoding, for status LEDs

## Operation
- Each btn bit: 2-flop synchronizer → debounce → rising-edge detect → one-cycle event (enter_evt, next_evt, exec_evt, clr_evt). sw is 2-flop synchronized only.
- States (stage): ENTER_A=0, ENTER_B=1, SELECT=2, WAIT_ACK=3.
- ENTER_A: enter_evt → op_a ← sw_sync[3:0], go ENTER_B.
- ENTER_B: enter_evt → op_b ← sw_sync[3:0], go SELECT.
- SELECT: next_evt → opcode ← (opcode==OP_COUNT-1) ? 0 : opcode+1; exec_evt → cmd_valid←1, go WAIT_ACK.
- WAIT_ACK: cmd_valid=1; op_a/op_b/opcode frozen; cmd_ready=1 → cmd_valid←0, go SELECT (same operands, new op may be chosen). All button events ignored, including clear.
- clr_evt in ENTER_A/ENTER_B/SELECT → op_a, op_b, opcode ← 0, go ENTER_A.
- Simultaneous events same cycle: clear > execute > enter > next; lower-priority events that cycle are discarded.
- Events not listed for a state are ignored (no state change).

## Timing
- Reset values: op_a=0, op_b=0, opcode=0, cmd_valid=0, stage=0 (ENTER_A); synchronizers, debounce counters and filtered states cleared to 0.
- Debounce: counter increments while sync sample ≠ filtered state, clears otherwise; filtered state toggles when counter reaches DEBOUNCE_CYCLES-1 with mismatch.
- Latency: raw btn high from cycle n (held) → event asserted in cycle n+2+DEBOUNCE_CYCLES, exactly one cycle wide; held button produces no further events; glitches shorter than DEBOUNCE_CYCLES produce none.
- State/output update registered on the cycle after the event.
- cmd_valid, once high, stays high with stable payload until the cycle where cmd_ready=1 is sampled; cmd_valid low the following cycle. cmd_ready while cmd_valid=0 has no effect.
- Reset asserted mid-handshake: cmd_valid drops immediately (asynchronous).

## Configuration
- OPERAND_ENTRY_DEBOUNCE_EN defined: debounce filter as above.
- Undefined: filter bypassed; filtered state = synchronized sample; event latency = 3 cycles (n+3). Intended for fast simulation; DEBOUNCE_CYCLES unused.

## Structure
- Shared package calc_pkg: opcode enum (11 values above), OP_COUNT constant, entry state enum (ENTER_A..WAIT_ACK).
- Sub-module button_debounce (synchronizer + filter + edge detect, parameter DEBOUNCE_CYCLES, macro-controlled bypass), instantiated four times.

## Test plan
- Reset, DEBOUNCE_CYCLES=4: sw=0x05 enter, sw=0x03 enter, exec → cmd_valid with op_a=5, op_b=3, opcode=0, stage=3.
- Bounce: btn[0] pulses high 2 cycles, low 1, high 2 → no event; then held 10 cycles → exactly one enter_evt at n+6.
- Opcode wrap: in SELECT press next 11 times → opcode returns to 0; 3 presses → 3.
- Handshake: hold cmd_ready=0 for 20 cycles with clear and next pressed → payload and cmd_valid unchanged; cmd_ready=1 one cycle → cmd_valid=0, stage=2.
- Priority: clear and exec events same cycle in SELECT → stage=0, all outputs 0, no cmd_valid.
- rst_n low mid WAIT_ACK → cmd_valid=0 immediately, all outputs at reset values.
